// File: rtl/cfg_chain_loader_if.sv
// Wishbone slave bundle for cfg_chain_loader: strobe/cycle/write-enable, select, address and data.
`default_nettype none

interface cfg_chain_loader_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_addr_i;
  logic [31:0] wbs_data_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_data_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_addr_i, wbs_data_i,
    input  wbs_ack_o, wbs_data_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_addr_i, wbs_data_i,
    output wbs_ack_o, wbs_data_o
  );
endinterface

`default_nettype wire

// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader: Wishbone-fed FIFO that serialises 32-bit words onto per-column config chains.
// Optional frame counter at offset 0xC is built when CFG_LOADER_COUNT_EN is defined.
`default_nettype none

module cfg_chain_loader #(
  parameter int          NUM_COLS    = 4,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          FRAME_WORDS = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000
) (
  input  wire logic              wb_clk_i,
  input  wire logic              wb_rst_ni,
  cfg_chain_loader_if.slave      wbs,
  output logic                   cen,
  output logic [NUM_COLS-1:0]    shift_out,
  output logic [NUM_COLS-1:0]    set_out
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_load  = 2'd1;
  localparam logic [1:0] c_st_shift = 2'd2;
  localparam logic [1:0] c_st_set   = 2'd3;

  localparam logic [1:0] c_off_ctrl   = 2'd0;
  localparam logic [1:0] c_off_status = 2'd1;
  localparam logic [1:0] c_off_data   = 2'd2;

  localparam logic [LW-1:0] c_full_lvl = LW'(FIFO_DEPTH);
  localparam logic [7:0]    c_frame    = 8'(FRAME_WORDS);

  logic [1:0]          r_state, w_next;
  logic                r_en;
  logic [NUM_COLS-1:0] r_mask, r_frame_mask;
  logic [31:0]         r_mem [FIFO_DEPTH];
  logic [PW-1:0]       r_wptr, r_rptr;
  logic [LW-1:0]       r_level;
  logic [31:0]         r_sreg;
  logic [4:0]          r_bit;
  logic [7:0]          r_idx;
  logic                r_ack;
  logic [31:0]         r_rdata;

  logic        w_hit, w_full, w_empty, w_data_wr, w_stall, w_accept;
  logic        w_push, w_pop, w_ctrl_wr, w_abort, w_shift_last;
  logic [1:0]  w_off;
  logic [7:0]  w_idx_inc;
  logic [31:0] w_ctrl_rd, w_status_rd, w_cnt_rd, w_rd_mux, w_ctrl_merge;
  logic        w_unused;

  assign w_hit     = wbs.wbs_stb_i & wbs.wbs_cyc_i & (wbs.wbs_addr_i[31:4] == BASE_ADDR[31:4]);
  assign w_off     = wbs.wbs_addr_i[3:2];
  assign w_full    = (r_level == c_full_lvl);
  assign w_empty   = (r_level == '0);
  assign w_data_wr = w_hit & wbs.wbs_we_i & (w_off == c_off_data);
  // A full FIFO only back-pressures full-word writes; partial writes are dropped and acked at once.
  assign w_stall   = w_data_wr & (wbs.wbs_sel_i == 4'hF) & w_full;
  assign w_accept  = w_hit & ~r_ack & ~w_stall;
  assign w_push    = w_accept & w_data_wr & (wbs.wbs_sel_i == 4'hF);
  assign w_ctrl_wr = w_accept & wbs.wbs_we_i & (w_off == c_off_ctrl);
  assign w_abort   = w_ctrl_wr & wbs.wbs_sel_i[0] & wbs.wbs_data_i[1];
  assign w_pop     = (r_state == c_st_load) & ~w_abort;
  assign w_shift_last = (r_state == c_st_shift) & (r_bit == 5'd31);
  assign w_idx_inc = r_idx + 8'd1;
  assign w_unused  = ^{wbs.wbs_addr_i[1:0], w_ctrl_merge};

  always_comb begin
    w_ctrl_rd = '0;
    w_ctrl_rd[0] = r_en;
    w_ctrl_rd[4 +: NUM_COLS] = r_mask;
    w_status_rd = '0;
    w_status_rd[0]     = (r_state != c_st_idle);
    w_status_rd[1]     = w_full;
    w_status_rd[2]     = w_empty;
    w_status_rd[15:8]  = 8'(r_level);
    w_status_rd[23:16] = r_idx;
    for (int b = 0; b < 4; b++) begin
      w_ctrl_merge[8*b +: 8] = wbs.wbs_sel_i[b] ? wbs.wbs_data_i[8*b +: 8] : w_ctrl_rd[8*b +: 8];
    end
    case (w_off)
      c_off_ctrl:   w_rd_mux = w_ctrl_rd;
      c_off_status: w_rd_mux = w_status_rd;
      c_off_data:   w_rd_mux = 32'd0;
      default:      w_rd_mux = w_cnt_rd;
    endcase
  end

`ifdef CFG_LOADER_COUNT_EN
  logic [15:0] r_frame_cnt;
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)                r_frame_cnt <= 16'd0;
    else if (r_state == c_st_set)  r_frame_cnt <= r_frame_cnt + 16'd1;
  end
  assign w_cnt_rd = {16'd0, r_frame_cnt};
`else
  assign w_cnt_rd = 32'd0;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_ack   <= 1'b0;
      r_rdata <= 32'd0;
      r_en    <= 1'b0;
      r_mask  <= '0;
    end else begin
      r_ack   <= w_accept;
      r_rdata <= (w_accept & ~wbs.wbs_we_i) ? w_rd_mux : 32'd0;
      if (w_ctrl_wr) begin
        r_en   <= w_ctrl_merge[0];
        r_mask <= w_ctrl_merge[4 +: NUM_COLS];
      end
    end
  end

  assign wbs.wbs_ack_o  = r_ack;
  assign wbs.wbs_data_o = r_rdata;

  always_ff @(posedge wb_clk_i) begin
    if (w_push) r_mem[r_wptr] <= wbs.wbs_data_i;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (w_abort) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_sreg       <= 32'd0;
      r_bit        <= 5'd0;
      r_idx        <= 8'd0;
      r_frame_mask <= '0;
    end else if (w_abort) begin
      r_bit <= 5'd0;
      r_idx <= 8'd0;
    end else begin
      case (r_state)
        c_st_load: begin
          r_sreg <= r_mem[r_rptr];
          r_bit  <= 5'd0;
          if (r_idx == 8'd0) r_frame_mask <= r_mask;
        end
        c_st_shift: begin
          r_sreg <= r_sreg >> 1;
          r_bit  <= r_bit + 5'd1;
          if (r_bit == 5'd31) r_idx <= w_idx_inc;
        end
        c_st_set: r_idx <= 8'd0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) r_state <= c_st_idle;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_idle:  if (r_en & ~w_empty) w_next = c_st_load;
      c_st_load:  w_next = c_st_shift;
      c_st_shift: begin
        if (w_shift_last) begin
          if (w_idx_inc == c_frame)    w_next = c_st_set;
          else if (r_en & ~w_empty)    w_next = c_st_load;
          else                         w_next = c_st_idle;
        end
      end
      default:    w_next = c_st_idle;
    endcase
    if (w_abort) w_next = c_st_idle;
  end

  always_comb begin
    cen       = 1'b0;
    shift_out = '0;
    set_out   = '0;
    case (r_state)
      c_st_shift: begin
        cen       = 1'b1;
        shift_out = r_frame_mask & {NUM_COLS{r_sreg[0]}};
      end
      c_st_set: set_out = r_frame_mask;
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_cfg_chain_loader.sv
// Directed bench: two loaders OR-ed on one Wishbone bus (A: one word per frame, B: four words per frame).
`default_nettype none

module tb_cfg_chain_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'd0, wdat = 32'd0;

  logic       cen_a, cen_b;
  logic [3:0] shift_a, shift_b, set_a, set_b;
  logic       bus_ack;
  logic [31:0] bus_dat;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  cfg_chain_loader_if u_if_a ();
  cfg_chain_loader_if u_if_b ();

  assign u_if_a.wbs_stb_i = stb;  assign u_if_b.wbs_stb_i = stb;
  assign u_if_a.wbs_cyc_i = cyc;  assign u_if_b.wbs_cyc_i = cyc;
  assign u_if_a.wbs_we_i  = we;   assign u_if_b.wbs_we_i  = we;
  assign u_if_a.wbs_sel_i = sel;  assign u_if_b.wbs_sel_i = sel;
  assign u_if_a.wbs_addr_i = adr; assign u_if_b.wbs_addr_i = adr;
  assign u_if_a.wbs_data_i = wdat; assign u_if_b.wbs_data_i = wdat;
  assign bus_ack = u_if_a.wbs_ack_o | u_if_b.wbs_ack_o;
  assign bus_dat = u_if_a.wbs_data_o | u_if_b.wbs_data_o;

  cfg_chain_loader #(.FRAME_WORDS(1), .BASE_ADDR(32'h3000_0000)) u_dut_a (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs(u_if_a.slave),
    .cen(cen_a), .shift_out(shift_a), .set_out(set_a)
  );

  cfg_chain_loader #(.FRAME_WORDS(4), .BASE_ADDR(32'h3000_0010)) u_dut_b (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs(u_if_b.slave),
    .cen(cen_b), .shift_out(shift_b), .set_out(set_b)
  );

  localparam logic [31:0] A_CTRL = 32'h3000_0000, A_STAT = 32'h3000_0004;
  localparam logic [31:0] A_DATA = 32'h3000_0008, A_CNT  = 32'h3000_000C;
  localparam logic [31:0] B_CTRL = 32'h3000_0010, B_STAT = 32'h3000_0014;
  localparam logic [31:0] B_DATA = 32'h3000_0018;

  // Chain monitors: record every enabled shift cycle and every latch pulse.
  logic rec_a0 [1024];
  logic rec_a1 [1024];
  logic rec_ahi[1024];
  int cnt_a = 0, sets_a = 0, cnt_b = 0, sets_b = 0, ovl = 0;
  logic [3:0] last_set_a = 4'h0;

  always @(negedge clk) begin
    if (cen_a) begin
      if (cnt_a < 1024) begin
        rec_a0[cnt_a]  = shift_a[0];
        rec_a1[cnt_a]  = shift_a[1];
        rec_ahi[cnt_a] = |shift_a[3:2];
      end
      cnt_a++;
    end
    if (|set_a) begin sets_a++; last_set_a = set_a; end
    if (cen_b) cnt_b++;
    if (|set_b) sets_b++;
    if ((cen_a && |set_a) || (!cen_a && |shift_a) || (cen_b && |set_b) || (!cen_b && |shift_b)) ovl++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wb_xfer(input logic i_we, input logic [31:0] i_adr, input logic [31:0] i_dat,
                         input logic [3:0] i_sel, input int budget,
                         output logic [31:0] o_rd, output logic o_ack);
    int n;
    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = i_we; adr = i_adr; wdat = i_dat; sel = i_sel;
    o_ack = 1'b0; o_rd = 32'd0; n = 0;
    while (!o_ack && n < budget) begin
      @(negedge clk);
      o_rd = bus_dat;
      if (bus_ack) o_ack = 1'b1;
      n++;
    end
    @(posedge clk); #1;
    stb = 1'b0; cyc = 1'b0; we = 1'b0; adr = 32'd0; wdat = 32'd0; sel = 4'h0;
  endtask

  function automatic logic [31:0] word_of(input int base, input int which);
    logic [31:0] w;
    for (int k = 0; k < 32; k++)
      w[k] = (which == 0) ? rec_a0[base+k] : (which == 1) ? rec_a1[base+k] : rec_ahi[base+k];
    return w;
  endfunction

  initial begin
    logic [31:0] rd;
    logic        ak;
    int          base, snap, acks, guard;

    #3 rst_n = 1'b0;
    #1 check_eq("rst_outputs", {19'd0, cen_a, shift_a, set_a, cen_b, shift_b, set_b, bus_ack}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wb_xfer(1'b0, A_STAT, 0, 4'hF, 8, rd, ak); check_eq("rst_status", rd, 32'h4);
    wb_xfer(1'b0, A_CTRL, 0, 4'hF, 8, rd, ak); check_eq("rst_ctrl", rd, 32'h0);

    // Address miss and partial DATA write
    wb_xfer(1'b0, 32'h3000_0100, 0, 4'hF, 6, rd, ak);
    check_eq("miss_ack", {31'd0, ak}, 32'd0);
    check_eq("miss_data", rd, 32'd0);
    wb_xfer(1'b1, A_DATA, 32'hDEAD_BEEF, 4'h3, 8, rd, ak);
    check_eq("sel3_ack", {31'd0, ak}, 32'd1);
    wb_xfer(1'b0, A_STAT, 0, 4'hF, 8, rd, ak); check_eq("sel3_level", rd, 32'h4);

    // Single-word frame on columns 0,1
    wb_xfer(1'b1, A_CTRL, 32'h31, 4'hF, 8, rd, ak);
    wb_xfer(1'b0, A_CTRL, 0, 4'hF, 8, rd, ak); check_eq("ctrl_rb", rd, 32'h31);
    wb_xfer(1'b1, A_CTRL, 32'h0, 4'hE, 8, rd, ak);
    wb_xfer(1'b0, A_CTRL, 0, 4'hF, 8, rd, ak); check_eq("ctrl_bytesel", rd, 32'h31);
    wb_xfer(1'b1, A_DATA, 32'hA5A5_A5A5, 4'hF, 8, rd, ak);
    guard = 0; while (sets_a < 1 && guard < 200) begin @(negedge clk); guard++; end
    check_eq("f1_sets", sets_a, 1);
    check_eq("f1_cen_cycles", cnt_a, 32);
    check_eq("f1_col0", word_of(0, 0), 32'hA5A5_A5A5);
    check_eq("f1_col1", word_of(0, 1), 32'hA5A5_A5A5);
    check_eq("f1_col23", word_of(0, 2), 32'd0);
    check_eq("f1_set_val", {28'd0, last_set_a}, 32'h3);

    // FIFO back-pressure while disabled
    wb_xfer(1'b1, A_CTRL, 32'h30, 4'hF, 8, rd, ak);
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      wb_xfer(1'b1, A_DATA, 32'h1111_0000 + i, 4'hF, 8, rd, ak);
      if (ak) acks++;
    end
    check_eq("fill_acks", acks, 4);
    wb_xfer(1'b1, A_DATA, 32'h5555_5555, 4'hF, 8, rd, ak);
    check_eq("full_noack", {31'd0, ak}, 32'd0);
    wb_xfer(1'b0, A_STAT, 0, 4'hF, 8, rd, ak); check_eq("full_status", rd, 32'h402);
    wb_xfer(1'b1, A_CTRL, 32'h31, 4'hF, 8, rd, ak);
    wb_xfer(1'b1, A_DATA, 32'h5555_5555, 4'hF, 20, rd, ak);
    check_eq("fifth_ack", {31'd0, ak}, 32'd1);
    wb_xfer(1'b0, A_STAT, 0, 4'hF, 8, rd, ak); check_eq("busy_status", rd, 32'h403);
    guard = 0; while (sets_a < 6 && guard < 400) begin @(negedge clk); guard++; end
    check_eq("drain_sets", sets_a, 6);
    check_eq("drain_cen", cnt_a, 192);
    check_eq("drain_last_word", word_of(160, 0), 32'h5555_5555);
    wb_xfer(1'b0, A_STAT, 0, 4'hF, 8, rd, ak); check_eq("drain_status", rd, 32'h4);

    // Abort in the third word of a four-word frame on loader B
    for (int i = 0; i < 4; i++) wb_xfer(1'b1, B_DATA, 32'hF0F0_0000 + i, 4'hF, 8, rd, ak);
    wb_xfer(1'b1, B_CTRL, 32'h31, 4'hF, 8, rd, ak);
    guard = 0; while (cnt_b < 74 && guard < 300) begin @(negedge clk); guard++; end
    check_eq("b_reach_word3", {31'd0, (cnt_b >= 74)}, 32'd1);
    wb_xfer(1'b1, B_CTRL, 32'h2, 4'hF, 8, rd, ak);
    check_eq("abort_ack", {31'd0, ak}, 32'd1);
    check_eq("abort_outs", {23'd0, cen_b, shift_b, set_b}, 32'd0);
    snap = cnt_b;
    wb_xfer(1'b0, B_STAT, 0, 4'hF, 8, rd, ak); check_eq("abort_status", rd, 32'h4);
    repeat (40) @(negedge clk);
    check_eq("abort_no_shift", cnt_b, snap);
    check_eq("abort_no_set", sets_b, 0);

    // Reset in the middle of a shift, then three clean frames
    base = cnt_a;
    wb_xfer(1'b1, A_DATA, 32'h0000_FFFF, 4'hF, 8, rd, ak);
    guard = 0; while (cnt_a < base + 5 && guard < 50) begin @(negedge clk); guard++; end
    snap = sets_a;
    #2 rst_n = 1'b0;
    #1 check_eq("midrst_outs", {19'd0, cen_a, shift_a, set_a, cen_b, shift_b, set_b, bus_ack}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("midrst_no_set", sets_a, snap);
    wb_xfer(1'b0, A_STAT, 0, 4'hF, 8, rd, ak); check_eq("midrst_status", rd, 32'h4);
    wb_xfer(1'b0, A_CTRL, 0, 4'hF, 8, rd, ak); check_eq("midrst_ctrl", rd, 32'h0);
    wb_xfer(1'b1, A_CTRL, 32'h31, 4'hF, 8, rd, ak);
    base = cnt_a;
    wb_xfer(1'b1, A_DATA, 32'h1234_5678, 4'hF, 8, rd, ak);
    guard = 0; while (sets_a < snap + 1 && guard < 200) begin @(negedge clk); guard++; end
    check_eq("post_sets", sets_a, snap + 1);
    check_eq("post_cen", cnt_a - base, 32);
    check_eq("post_col0", word_of(base, 0), 32'h1234_5678);
    wb_xfer(1'b1, A_DATA, 32'h1, 4'hF, 8, rd, ak);
    wb_xfer(1'b1, A_DATA, 32'h2, 4'hF, 8, rd, ak);
    guard = 0; while (sets_a < snap + 3 && guard < 300) begin @(negedge clk); guard++; end
    check_eq("three_sets", sets_a, snap + 3);
    wb_xfer(1'b0, A_CNT, 0, 4'hF, 8, rd, ak);
`ifdef CFG_LOADER_COUNT_EN
    check_eq("frame_count", rd, 32'd3);
`else
    check_eq("frame_count", rd, 32'd0);
`endif
    check_eq("cen_set_overlap", ovl, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cfg_chain_loader.md
CFG_CHAIN_LOADER -- requirements
Module: cfg_chain_loader

Interface
REQ-001 SHALL have parameter NUM_COLS, default 4: number of fabric columns driven; 1..8.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: depth of the write-data FIFO in 32-bit words; power of two, 2..16.
REQ-003 SHALL have parameter FRAME_WORDS, default 8: number of 32-bit words per column configuration frame; 1..255.
REQ-004 SHALL have parameter BASE_ADDR, default 32'h3000_0000: Wishbone base address, 16-byte aligned.
REQ-005 SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-006 SHALL have port wb_clk_i, input, 1 bit: fabric and Wishbone clock.
REQ-007 SHALL have port wb_rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have ports wbs_stb_i, wbs_cyc_i, wbs_we_i, inputs, 1 bit each: Wishbone strobe, cycle and write-enable.
REQ-009 SHALL have port wbs_sel_i, input, 4 bits: byte select.
REQ-010 SHALL have ports wbs_addr_i and wbs_data_i, inputs, 32 bits each: address and write data.
REQ-011 SHALL have port wbs_ack_o, output, 1 bit, and port wbs_data_o, output, 32 bits: acknowledge and read data.
REQ-012 SHALL have port cen, output, 1 bit: configuration enable to the columns.
REQ-013 SHALL have port shift_out, output, NUM_COLS bits: serial configuration data, one bit per column.
REQ-014 SHALL have port set_out, output, NUM_COLS bits: frame latch pulse, one bit per column.

Function
REQ-015 SHALL decode a hit as stb&cyc&(addr[31:4]==BASE_ADDR[31:4]) and use addr[3:2] as the register offset.
REQ-016 SHALL keep wbs_ack_o and wbs_data_o at 0 on a miss, so that several instances can be OR-ed onto one bus.
REQ-017 SHALL assert wbs_ack_o for exactly one cycle, in the cycle after the hit is sampled, and SHALL hold it low for one cycle before the next ack.
REQ-018 SHALL provide register CTRL at offset 0x0 (R/W): bit0 enable; bit1 abort (write-only, self-clearing, reads 0); bits[4+NUM_COLS-1:4] column mask.
REQ-019 SHALL provide register STATUS at offset 0x4 (RO): bit0 busy (state != IDLE); bit1 FIFO full; bit2 FIFO empty; bits[15:8] FIFO level; bits[23:16] word-in-frame index.
REQ-020 SHALL treat a write to DATA at offset 0x8 as a FIFO push; when the FIFO is full, SHALL withhold ack until space frees, then push and ack.
REQ-021 SHALL ignore, but still ack, a DATA write with wbs_sel_i!=4'hF; SHALL apply a CTRL write only to the bytes selected by wbs_sel_i.
REQ-022 SHALL read 0 from DATA and from any write-only field.
REQ-023 SHALL implement FSM states IDLE, LOAD, SHIFT and SET.
REQ-024 SHALL go IDLE->LOAD when enable=1 and the FIFO is non-empty.
REQ-025 SHALL in LOAD (1 cycle) pop one word into a 32-bit shift register; when the word-in-frame index is 0, SHALL also latch the column mask for the whole frame.
REQ-026 SHALL in SHIFT (exactly 32 cycles) drive bit k, LSB first, on cycle k onto shift_out[c] for every masked column c (0 on unmasked columns), with cen=1.
REQ-027 SHALL at the end of SHIFT increment the word index; if the index then equals FRAME_WORDS, SHALL go to SET, else to LOAD if the FIFO is non-empty and enabled, else to IDLE, keeping the index.
REQ-028 SHALL in SET (1 cycle) assert set_out equal to the latched mask, hold cen=0, clear the index and return to IDLE.
REQ-029 SHALL hold cen=0, shift_out=0 and set_out=0 in IDLE, LOAD and SET, except that SET drives set_out per REQ-028.
REQ-030 SHALL, when enable is cleared mid-word, finish the current SHIFT and then stop in IDLE.
REQ-031 SHALL on abort, in the next cycle: flush the FIFO, clear the index, enter IDLE and force cen, shift_out and set_out to 0, with no SET pulse.
REQ-032 SHALL give precedence to abort over a concurrent pop, and SHALL let a simultaneous push and pop leave the FIFO level unchanged.

Reset
REQ-033 SHALL on wb_rst_ni=0 asynchronously clear the FSM to IDLE, the FIFO pointers and level, the index, CTRL and the frame counter, and drive every output to 0.
REQ-034 SHALL, on reset asserted mid-frame, discard the partial frame with no set_out pulse.

Configuration
REQ-035 SHALL, with CFG_LOADER_COUNT_EN defined, implement a 16-bit frame counter at offset 0xC (RO) that increments in every SET cycle, wraps at 0xFFFF->0 and is cleared by reset only.
REQ-036 SHALL, without CFG_LOADER_COUNT_EN, read offset 0xC as 0 and implement no counter logic.

Verification
REQ-037 SHALL cover: CTRL=0x31 (enable, mask 0b0011), FRAME_WORDS=1, DATA=0xA5A5A5A5 -> 32 cen cycles, shift_out[1:0] carries the pattern LSB first, shift_out[3:2]=0, then one set_out=4'b0011 pulse.
REQ-038 SHALL cover: with enable=0, 5 DATA writes at FIFO_DEPTH=4 -> the 5th write gets no ack and STATUS.full=1; set enable -> the 5th write acks after the first pop.
REQ-039 SHALL cover: abort issued at SHIFT cycle 10 of word 3 -> cen=0 next cycle, STATUS=0x04 (empty, index 0), no set_out pulse.
REQ-040 SHALL cover: wb_rst_ni pulsed low mid-SHIFT -> all outputs 0 immediately, and the next full frame completes normally.
REQ-041 SHALL cover: read of an address outside BASE_ADDR -> no ack and wbs_data_o=0; a DATA write with sel=4'h3 -> acked, FIFO level unchanged.
REQ-042 SHALL cover: with CFG_LOADER_COUNT_EN, 3 frames -> offset 0xC reads 3; without the macro it reads 0.
